// File: rtl/mult_pkg.sv
// Shared constants, Booth digit type and elaboration helpers for the 32x32 multiplier.
// The MULT_SIGNED_EN macro (used by booth_wallace_mult_32) selects two's-complement operands.
// Pure definitions: no logic, no latency, no backpressure.
package mult_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int NUM_PP = 17;
  localparam int PP_W   = OP_W + 2;   // extended multiplicand / partial-product row width
  localparam int NUM_OPS = NUM_PP + 2; // PP rows + neg-bit row + sign-extension constant

  // Radix-4 Booth digit: magnitude one-hot (one/two) plus sign
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  // Recode triplet {b[2i+1], b[2i], b[2i-1]}; zero digits (000, 111) never assert neg
  function automatic booth_dig_t booth_enc(input logic [2:0] t);
    booth_dig_t d;
    d.one = t[1] ^ t[0];
    d.two = (t == 3'b011) || (t == 3'b100);
    d.neg = t[2] & ~(t[1] & t[0]);
    return d;
  endfunction

  // Each row carries an inverted sign bit, i.e. it is biased by +2^(PP_W-1) at its
  // own weight; this constant removes the sum of all those biases (mod 2^64).
  function automatic logic [PROD_W-1:0] sext_const();
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      acc = acc + (PROD_W'(1) << (PP_W - 1 + 2 * i));
    end
    return ~acc + PROD_W'(1);
  endfunction

  // Operand count after one layer of 3:2 compression
  function automatic int csa_next(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  // Operand count after l layers starting from n
  function automatic int csa_count(input int n, input int l);
    int m;
    m = n;
    for (int j = 0; j < l; j++) begin
      m = csa_next(m);
    end
    return m;
  endfunction

  // Layers needed to reach two vectors
  function automatic int csa_levels(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = csa_next(m);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial-product row: selects 0, +-a or +-2a from a 3-bit triplet.
// Purely combinational, zero latency.
// No handshake; row is emitted with its sign bit inverted and the +1 of negation as pp_neg.
module booth_pp_gen
  import mult_pkg::*;
(
  input  logic [2:0]      trip,
  input  logic [PP_W-1:0] a_ext,
  output logic [PP_W-1:0] pp_row,
  output logic            pp_neg
);

  booth_dig_t          dig;
  logic [PP_W-1:0]     mag;
  logic [PP_W-1:0]     raw;

  // Magnitude select, one's-complement on negative digits, sign bit inverted for
  // the constant sign-extension scheme
  always_comb begin
    dig = booth_enc(trip);
    mag = '0;
    if (dig.two) begin
      mag = {a_ext[PP_W-2:0], 1'b0};
    end else if (dig.one) begin
      mag = a_ext;
    end
    raw    = mag ^ {PP_W{dig.neg}};
    pp_row = {~raw[PP_W-1], raw[PP_W-2:0]};
    pp_neg = dig.neg;
  end

endmodule

// File: rtl/booth_wallace_mult_32.sv
// 32x32->64 radix-4 Booth / Wallace-tree multiplier; MULT_SIGNED_EN selects signed operands.
// Latency 3 clocks (input reg, carry-save reg, result reg), one product per cycle.
// No backpressure: every cycle is accepted; valid_in travels with the data to valid_out.
module booth_wallace_mult_32
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              valid_out,
  output logic [PROD_W-1:0] result
);

  localparam int TREE_LVLS = csa_levels(NUM_OPS);
  localparam logic [PROD_W-1:0] SEXT_C = sext_const();

  // Pipeline state
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic              vld0_q, vld0_d;
  logic [PROD_W-1:0] sum_q, sum_d;
  logic [PROD_W-1:0] cry_q, cry_d;
  logic              vld1_q, vld1_d;
  logic [PROD_W-1:0] result_q, result_d;
  logic              vld2_q, vld2_d;

  // Operand extension and Booth partial products
  logic [PP_W-1:0]   a_ext;
  logic [PP_W-1:0]   b_ext;
  logic [PP_W:0]     b_pad;
  logic [PP_W-1:0]   pp_row [NUM_PP];
  logic [NUM_PP-1:0] pp_neg;
  logic [PROD_W-1:0] neg_vec;

  // Reduction tree: level 0 holds all operands, last level holds sum/carry
  logic [PROD_W-1:0] tree [TREE_LVLS+1][NUM_OPS];

  // Two-bit extension of both operands; b also gets the implicit b[-1] = 0
  always_comb begin
`ifdef MULT_SIGNED_EN
    a_ext = {{2{a_q[OP_W-1]}}, a_q};
    b_ext = {{2{b_q[OP_W-1]}}, b_q};
`else
    a_ext = {2'b00, a_q};
    b_ext = {2'b00, b_q};
`endif
    b_pad = {b_ext, 1'b0};
  end

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen u_pp (
      .trip   (b_pad[2*i+2 -: 3]),
      .a_ext  (a_ext),
      .pp_row (pp_row[i]),
      .pp_neg (pp_neg[i])
    );
    assign tree[0][i] = PROD_W'(pp_row[i]) << (2 * i);
  end

  // Negation +1 bits land on each row's LSB column; the columns are disjoint so one row holds them all
  always_comb begin
    neg_vec = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      neg_vec[2*i] = pp_neg[i];
    end
  end

  assign tree[0][NUM_PP]   = neg_vec;
  assign tree[0][NUM_PP+1] = SEXT_C;

  // Wallace layers: each group of three rows becomes sum + shifted carry via per-column full adders
  for (genvar l = 0; l < TREE_LVLS; l++) begin : g_lvl
    localparam int N_IN  = csa_count(NUM_OPS, l);
    localparam int N_OUT = csa_count(NUM_OPS, l + 1);
    localparam int N_GRP = N_IN / 3;

    for (genvar g = 0; g < N_GRP; g++) begin : g_csa
      logic [PROD_W-1:0] s_v;
      logic [PROD_W-1:1] c_v;
      for (genvar c = 0; c < PROD_W; c++) begin : g_col
        assign s_v[c] = tree[l][3*g][c] ^ tree[l][3*g+1][c] ^ tree[l][3*g+2][c];
        // carry out of column 63 falls outside the 64-bit product and is dropped
        if (c < PROD_W - 1) begin : g_cy
          assign c_v[c+1] = (tree[l][3*g][c]   & tree[l][3*g+1][c]) |
                            (tree[l][3*g][c]   & tree[l][3*g+2][c]) |
                            (tree[l][3*g+1][c] & tree[l][3*g+2][c]);
        end
      end
      assign tree[l+1][2*g]   = s_v;
      assign tree[l+1][2*g+1] = {c_v, 1'b0};
    end

    for (genvar k = 3 * N_GRP; k < N_IN; k++) begin : g_pass
      assign tree[l+1][2*N_GRP + k - 3*N_GRP] = tree[l][k];
    end

    for (genvar k = N_OUT; k < NUM_OPS; k++) begin : g_idle
      assign tree[l+1][k] = '0;
    end
  end

  // Next-state for all pipeline stages, including the final carry-propagate add
  always_comb begin
    a_d      = a;
    b_d      = b;
    vld0_d   = valid_in;
    sum_d    = tree[TREE_LVLS][0];
    cry_d    = tree[TREE_LVLS][1];
    vld1_d   = vld0_q;
    result_d = sum_q + cry_q;
    vld2_d   = vld1_q;
  end

  // Stage 0: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      vld0_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      vld0_q <= vld0_d;
    end
  end

  // Stage 1: carry-save pair from the tree
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cry_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cry_q  <= cry_d;
      vld1_q <= vld1_d;
    end
  end

  // Stage 2: resolved product
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      vld2_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      vld2_q   <= vld2_d;
    end
  end

  assign result    = result_q;
  assign valid_out = vld2_q;

endmodule

// File: tb/tb_booth_wallace_mult_32.sv
// Self-checking bench for booth_wallace_mult_32 (honours MULT_SIGNED_EN like the design).
// Expected outputs come from native 64-bit arithmetic delayed three cycles.
// Inputs driven and outputs sampled on the falling edge.
module tb_booth_wallace_mult_32;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid_out;
  logic [63:0] result;

  int checks;
  int failures;

  // Expected output three rising edges after each drive; index 2 is due next
  logic [63:0] exp_res [3];
  logic        exp_vld [3];
  string       exp_tag [3];

  booth_wallace_mult_32 dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
`ifdef MULT_SIGNED_EN
    return {{32{x[31]}}, x} * {{32{y[31]}}, y};
`else
    return {32'd0, x} * {32'd0, y};
`endif
  endfunction

  // Compare the output that is due now, then drive the next input set and advance the model
  task automatic step(input logic r, input logic v, input logic [31:0] x, input logic [31:0] y,
                      input logic [63:0] e, input string tag);
    @(negedge clk);
    check({exp_tag[2], "/valid"}, 64'(valid_out), 64'(exp_vld[2]));
    check({exp_tag[2], "/result"}, result, exp_res[2]);
    rst      = r;
    valid_in = v;
    a        = x;
    b        = y;
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        exp_res[k] = '0;
        exp_vld[k] = 1'b0;
        exp_tag[k] = "reset";
      end
    end else begin
      exp_res[2] = exp_res[1];
      exp_vld[2] = exp_vld[1];
      exp_tag[2] = exp_tag[1];
      exp_res[1] = exp_res[0];
      exp_vld[1] = exp_vld[0];
      exp_tag[1] = exp_tag[0];
      exp_res[0] = e;
      exp_vld[0] = v;
      exp_tag[0] = tag;
    end
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e, input string tag);
    step(1'b0, 1'b1, x, y, e, tag);
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rv;
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 3; k++) begin
      exp_res[k] = '0;
      exp_vld[k] = 1'b0;
      exp_tag[k] = "reset";
    end
    rst      = 1'b1;
    valid_in = 1'b1;
    a        = 32'd5;
    b        = 32'd7;
    @(posedge clk);

    // Reset held with live inputs: outputs stay zero
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'd5, 32'd7, 64'd0, "reset");
    op(32'd5, 32'd7, 64'd35, "rst_release_5x7");

    // Back-to-back basic values
    op(32'd0, 32'd0, 64'd0, "zero_zero");
    op(32'd4, 32'd25, 64'd100, "4x25");
    op(32'd2394324, 32'd394, 64'd943363656, "2394324x394");
    op(32'd3394, 32'd4925, 64'd16715450, "3394x4925");
    op(32'd0, 32'hDEADBEEF, 64'd0, "zero_a");
    op(32'h12345678, 32'd0, 64'd0, "zero_b");

`ifdef MULT_SIGNED_EN
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, "neg1_sq");
    op(32'h80000000, 32'h80000000, 64'h4000000000000000, "min_sq");
    op(32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, "m3x7");
    op(32'h80000000, 32'd2, 64'hFFFFFFFF00000000, "min_x2");
`else
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max_sq");
    op(32'h80000000, 32'd2, 64'h0000000100000000, "msb_x2");
    op(32'h80000000, 32'h80000000, 64'h4000000000000000, "msb_sq");
`endif

    // Valid gating 1,0,1: the idle slot still carries its product
    op(32'd11, 32'd13, 64'd143, "gate_1");
    step(1'b0, 1'b0, 32'd6, 32'd9, 64'd54, "gate_0");
    op(32'd100, 32'd1000, 64'd100000, "gate_1b");

    // Reset mid-flight discards everything in the pipe
    op(32'd3, 32'd3, 64'd9, "inflight_a");
    op(32'd4, 32'd4, 64'd16, "inflight_b");
    step(1'b1, 1'b1, 32'd7, 32'd7, 64'd0, "mid_reset");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 64'd0, "post_reset_idle");

    // Random operands, mostly valid
    for (int n = 0; n < 10000; n++) begin
      rx = $urandom;
      ry = $urandom;
      rv = ($urandom_range(0, 3) != 0);
      step(1'b0, rv, rx, ry, ref_mul(rx, ry), "random");
    end

    // Drain
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 64'd0, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
